// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Segment codes are {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Entry n is the code for hex digit n (index 15 listed first).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to 7-segment code lookup.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with blanking gaps.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int ON_CYCLES    = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IW      = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = 5 * NUM_DIGITS;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [IW-1:0]         r_idx;
    logic [PW-1:0]         r_pending;
    logic [PW-1:0]         r_active;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_frame_done;

    logic [PW-1:0]         w_load_val;
    logic [PW-1:0]         w_next_active;
    logic [3:0]            w_nibble;
    logic                  w_dp_cur;
    logic [6:0]            w_seg_dec;
    logic [6:0]            w_seg_show;
    logic                  w_suppress;
    logic [NUM_DIGITS-1:0] w_an_sel;

    // Packed layout: nibbles in the upper 4*N bits, decimal points in the low N bits.
    assign w_load_val    = {digits_in, dp_in};
    assign w_next_active = load ? w_load_val : r_pending;

    assign w_nibble = r_active[NUM_DIGITS + 4*int'(r_idx) +: 4];
    assign w_dp_cur = r_active[r_idx];
    assign w_an_sel = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx);

    seg7_decoder u_decoder (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_dec)
    );

    always_comb begin
        w_suppress = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        w_suppress = (r_idx != '0);
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(r_idx) && r_active[NUM_DIGITS + 4*j +: 4] != 4'h0)
                w_suppress = 1'b0;
        end
`endif
    end

    assign w_seg_show = w_suppress ? SEG_BLANK : w_seg_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_pending    <= '0;
            r_active     <= '0;
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b0;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (load)
                r_pending <= w_load_val;

            if (!enable) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_idx   <= '0;
                r_seg   <= SEG_BLANK;
                r_dp    <= 1'b0;
                r_an    <= '1;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state  <= BLANK;
                        r_cnt    <= '0;
                        r_idx    <= '0;
                        r_active <= w_next_active;
                        r_seg    <= SEG_BLANK;
                        r_dp     <= 1'b0;
                        r_an     <= '1;
                    end
                    BLANK: begin
                        if (r_cnt == BLANK_LAST) begin
                            // Segments, dp and anode switch together on this edge.
                            r_state <= SHOW;
                            r_cnt   <= '0;
                            r_an    <= w_an_sel;
                            r_seg   <= w_seg_show;
                            r_dp    <= w_dp_cur;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    SHOW: begin
                        if (r_cnt == ON_LAST) begin
                            r_state <= BLANK;
                            r_cnt   <= '0;
                            r_an    <= '1;
                            r_seg   <= SEG_BLANK;
                            r_dp    <= 1'b0;
                            if (r_idx == IDX_LAST) begin
                                r_idx        <= '0;
                                r_frame_done <= 1'b1;
                                r_active     <= w_next_active;
                            end else begin
                                r_idx <= r_idx + IW'(1);
                            end
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_seg   <= SEG_BLANK;
                        r_dp    <= 1'b0;
                        r_an    <= '1;
                    end
                endcase
            end
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. Holds one 4-bit hex nibble and a decimal point per digit. Cycles the anode enables one digit at a time, with a blanking gap between digits to prevent ghosting, and drives the shared segment bus through a hex-to-segment decoder. Sits between the register/CPU side, which loads the digit values, and the display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
ON_CYCLES, 1000, clk cycles each digit's anode is asserted (>=1)
BLANK_CYCLES, 8, clk cycles with all anodes off before each digit (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = scan running; 0 = display dark
load  input  1  1-cycle strobe; captures digits_in and dp_in into the pending register
digits_in  input  4*NUM_DIGITS  hex nibble per digit; digit 0 = bits [3:0] (rightmost)
dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit
seg  output  7  segments {g,f,e,d,c,b,a}, active-high
dp  output  1  decimal point for the current digit, active-high
an  output  NUM_DIGITS  anode enables, active-low, at most one bit low at any time
frame_done  output  1  1-cycle pulse after the last digit's ON period ends

Behaviour:
- Reset (async, rst_n=0): state IDLE; seg=0, dp=0, an=all 1s, frame_done=0; digit index=0; cycle counter=0; pending and active registers all 0. Reset mid-scan forces dark immediately, with no completion of the current digit.
- Register paths: pending <= {digits_in, dp_in} on any cycle with load=1. If several loads occur in one frame, the last one wins.
- Active copy: active <= pending only at frame boundaries (entering digit 0 from IDLE, or wrapping from digit NUM_DIGITS-1). If load=1 falls on the boundary cycle, the newly loaded value is the one copied. This rule prevents tearing within a frame.
- FSM states:
  - IDLE: an all 1s, seg=0, dp=0. When enable=1, go to BLANK with index=0 and the active copy taken.
  - BLANK: an all 1s, seg=0. Lasts BLANK_CYCLES cycles, then go to SHOW.
  - SHOW: an[index]=0, seg=decode(active nibble[index]), dp=active dp[index]. Lasts ON_CYCLES cycles.
    - At the end of SHOW, if index<NUM_DIGITS-1: index+1, go to BLANK.
    - At the end of SHOW, if index=NUM_DIGITS-1: index=0, frame_done pulses 1 cycle, active copy taken, go to BLANK.
- enable=0 in any state: IDLE on the next edge, an all 1s, counter and index cleared. frame_done does not pulse.
- All outputs are registered. seg, dp and an change on the same edge, so there is never a cycle with an anode low and stale segments.
- Frame period = NUM_DIGITS*(BLANK_CYCLES+ON_CYCLES) cycles. First anode falls BLANK_CYCLES+1 edges after enable rises from IDLE.
- Cycle counter width = $clog2(max(ON_CYCLES,BLANK_CYCLES)+1). Counter counts 0..N-1 and reloads 0 on state change.
- Decode (gfedcba hex):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - Input X/Z in simulation must not propagate to an.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: in SHOW, a digit i>=1 shows seg=0 if its nibble and all higher-index nibbles are 0; dp is still driven, and an timing is unchanged. Digit 0 is never suppressed, so all zeros displays "0".
- Undefined: every digit is decoded as stored.

Decomposition:
- Package seg7_pkg holds:
  - state enum {IDLE, BLANK, SHOW}
  - SEG_BLANK=7'h00 constant
  - 16-entry segment code constant table
- One sub-module, seg7_decoder: combinational 4-bit nibble to 7-bit segment code from the package table, instantiated once on the muxed nibble.

Test Plan:
1. Reset, NUM_DIGITS=4, ON_CYCLES=4, BLANK_CYCLES=2, load 16'h12AF, dp_in=4'b0100, enable=1 -> digit sequence:
   - an=1110 seg=71
   - an=1101 seg=77 dp=0
   - an=1011 seg=5B dp=1
   - an=0111 seg=06
   - each anode low exactly 4 cycles with 2 dark cycles between digits; frame_done pulses once per 24 cycles.
2. Load 16'h0000 mid-frame during digit 1 -> the current frame keeps showing the old values; from the next frame all digits show 3F. With LEADING_ZERO_BLANK_EN: digits 3..1 show 00 and digit 0 shows 3F.
3. Value 16'h0070 with LEADING_ZERO_BLANK_EN -> digit3=00, digit2=00, digit1=07, digit0=3F. Without the macro -> 3F,3F,07,3F.
4. Drop enable while an=1011 -> next edge an=1111, seg=00, no frame_done. Re-enable -> restart at digit 0 after 2 blank cycles.
5. Assert rst_n=0 asynchronously mid-SHOW (between edges) -> an=1111, seg=00 and dp=0 immediately; after release the active registers read 0.
6. Load on the exact wrap cycle with value 16'hFFFF -> the next frame shows 71 on all digits. Checker asserts at most one an bit low on every cycle.
